// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS cores.
// Shift-add multiply and restoring divide, one bit per cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               div_q, div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_tmp;
  logic               div_kept;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg    = ~op[0] & a[WIDTH-1];
  assign b_neg    = ~op[0] & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = op[1] & (b == '0);

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, dvsr_q} : '0);
  assign div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_kept = div_tmp >= {1'b0, dvsr_q};
  assign div_sub  = div_tmp[WIDTH-1:0] - dvsr_q;

  assign prod_fix = qneg_q ? -acc_q : acc_q;
  assign quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvsr_q  <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvsr_q  <= dvsr_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvsr_d  = dvsr_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !op[2]) begin
          state_d = CALC;
          cnt_d   = '0;
          div_d   = op[1];
          // A zero divisor keeps every bit: quotient all ones, rem = a.
          if (div_zero) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            dvsr_d = '0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            dvsr_d = b_mag;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
          end
        end else if (start && op == OP_MTHI) begin
          hi_d = a;
        end else if (start && op == OP_MTLO) begin
          lo_d = a;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (div_q) begin
          acc_d = {div_kept ? div_sub : div_tmp[WIDTH-1:0],
                   acc_q[WIDTH-2:0], div_kept};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit.
// Expected {hi,lo} queued at issue, popped when done rises.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    r = '0;
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = ux * uy;
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r = {sr[31:0], sq[31:0]};
        end
      end
      3'd3: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          r = {ur[31:0], uq[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drives one op; poke >= 0 fires a DIV start while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke,
                        input bit now, output int lat,
                        output int bcnt, output logic busy_at_done);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == poke) begin
        start = 1'b1; op = 3'b010; a = 32'h55; b = 32'h3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_state got b=%b d=%b hi=%h lo=%h exp all 0",
               busy, done, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b exp 0", busy);
    end
  endtask

  task automatic test_mult();
    logic [2:0]  to [2] = '{3'd0, 3'd1};
    logic [31:0] ta [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] tb [2] = '{32'd5, 32'd2};
    logic [63:0] te [2] = '{64'hFFFF_FFFF_FFFF_FFF1,
                            64'h0000_0001_FFFF_FFFE};
    int lat, bc;
    logic bd;
    logic [63:0] exp;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(te[i]);
      run_op(to[i], ta[i], tb[i], (i == 1) ? 5 : -1, 1'b0, lat, bc, bd);
      exp = sb.pop_front();
      checks++;
      if (lat !== 33 || bc !== 33 || bd !== 1'b0) begin
        errors++;
        $display("FAIL mult_timing[%0d] lat=%0d busy=%0d bd=%b exp 33/33/0",
                 i, lat, bc, bd);
      end
      checks++;
      if ({hi, lo} !== exp) begin
        errors++;
        $display("FAIL mult_result[%0d] got %h_%h exp %h", i, hi, lo, exp);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== exp) begin
        errors++;
        $display("FAIL mult_hold[%0d] d=%b b=%b got %h_%h exp %h",
                 i, done, busy, hi, lo, exp);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  to [4] = '{3'd3, 3'd2, 3'd2, 3'd3};
    logic [31:0] ta [4] = '{32'd100, 32'hFFFF_FFF9,
                            32'h8000_0000, 32'h1234};
    logic [31:0] tb [4] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] te [4] = '{{32'd2, 32'd14},
                            {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                            {32'h0, 32'h8000_0000},
                            {32'h1234, 32'hFFFF_FFFF}};
    int lat, bc;
    logic bd;
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(te[i]);
      run_op(to[i], ta[i], tb[i], -1, 1'b0, lat, bc, bd);
      exp = sb.pop_front();
      checks++;
      if (lat !== 33 || bc !== 33 || bd !== 1'b0) begin
        errors++;
        $display("FAIL div_timing[%0d] lat=%0d busy=%0d bd=%b exp 33/33/0",
                 i, lat, bc, bd);
      end
      checks++;
      if ({hi, lo} !== exp) begin
        errors++;
        $display("FAIL div_result[%0d] got %h_%h exp %h", i, hi, lo, exp);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL div_pulse[%0d] done got %b exp 0", i, done);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hCAFE_BABE; b = '0;
    @(negedge clk);
    checks++;
    if (hi !== 32'hCAFE_BABE || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi got hi=%h b=%b d=%b exp cafebabe/0/0",
               hi, busy, done);
    end
    op = 3'b101; a = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (lo !== 32'h1234_5678 || hi !== 32'hCAFE_BABE ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo got hi=%h lo=%h b=%b d=%b exp cafebabe/12345678",
               hi, lo, busy, done);
    end
    op = 3'b110; a = 32'hDEAD_0000;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_BABE || lo !== 32'h1234_5678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op got hi=%h lo=%h b=%b exp unchanged/0",
               hi, lo, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic bd;
    logic [63:0] exp;
    @(negedge clk);
    sb.push_back(64'd42);
    start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_async got b=%b d=%b hi=%h lo=%h exp all 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard b=%b d=%b exp 0/0", busy, done);
    end
    sb.push_back(64'd42);
    run_op(3'b000, 32'd6, 32'd7, -1, 1'b0, lat, bc, bd);
    exp = sb.pop_front();
    checks++;
    if (lat !== 33 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL reset_rerun lat=%0d got %h_%h exp 33 %h",
               lat, hi, lo, exp);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic bd;
    logic [2:0] o;
    logic [31:0] x, y;
    logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 20));
        2: y = -32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      sb.push_back(model(o, x, y));
      run_op(o, x, y, -1, i != 0, lat, bc, bd);
      exp = sb.pop_front();
      checks++;
      if (lat !== 33 || bd !== 1'b0 || {hi, lo} !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h lat=%0d got %h_%h exp %h",
                 i, o, x, y, lat, hi, lo, exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
